// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out transmitter with valid/ready word intake.
// Each accepted WIDTH-bit word is shifted out on sout, one bit per clk, with
// sout_valid framing the bits. Back-to-back words produce gapless frames.
// Optional build macro PISO_TX_PARITY_EN appends an even-parity bit to each
// frame, so a frame lasts WIDTH+1 cycles.
module piso_tx #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy
);

  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_shift;
  logic             r_sout;
  logic             r_sout_valid;
  logic             w_last;
  logic             w_accept;
  logic             w_first_bit;
  logic             w_next_bit;
`ifdef PISO_TX_PARITY_EN
  logic             r_par;
`endif

  assign w_last      = (r_state == SHIFT) && (r_count == LAST);
  assign w_accept    = in_valid & in_ready;
  assign w_first_bit = LSB_FIRST ? in_data[0] : in_data[WIDTH-1];
  assign w_next_bit  = LSB_FIRST ? r_shift[1] : r_shift[WIDTH-2];

`ifdef PISO_TX_PARITY_EN
  assign in_ready = reset_n & ((r_state == IDLE) | (r_state == PARITY));
`else
  assign in_ready = reset_n & ((r_state == IDLE) | w_last);
`endif

  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign busy       = (r_state != IDLE);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (w_accept) w_next = SHIFT;
      SHIFT: begin
        if (r_count == LAST) begin
`ifdef PISO_TX_PARITY_EN
          w_next = PARITY;
`else
          w_next = w_accept ? SHIFT : IDLE;
`endif
        end
      end
      PARITY: w_next = w_accept ? SHIFT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: the register holds the word, sout is registered one bit ahead
  // of the shift so the first bit appears the cycle after accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift      <= '0;
      r_count      <= '0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else if (w_accept) begin
      r_shift      <= in_data;
      r_count      <= '0;
      r_sout       <= w_first_bit;
      r_sout_valid <= 1'b1;
`ifdef PISO_TX_PARITY_EN
      r_par        <= ^in_data;
`endif
    end else begin
      unique case (r_state)
        SHIFT: begin
          if (r_count == LAST) begin
            r_count <= '0;
`ifdef PISO_TX_PARITY_EN
            r_sout       <= r_par;
            r_sout_valid <= 1'b1;
`else
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
`endif
          end else begin
            r_count      <= r_count + CW'(1);
            r_shift      <= LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);
            r_sout       <= w_next_bit;
            r_sout_valid <= 1'b1;
          end
        end
        default: begin
          r_sout       <= 1'b0;
          r_sout_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
